// File: rtl/cabac_pkg.sv
// Shared types and constants for the arithmetic bin decoder front end.
package cabac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT_HI = 2'd1,
    INIT_LO = 2'd2,
    RUN     = 2'd3
  } feeder_state_t;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam logic [BYTE_W-1:0] EPB_BYTE = 8'h03;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with a 0..4 byte MSB-first push and a single-byte pop per cycle.
// The caller guarantees enough free space for a push and a non-empty FIFO for a pop.
module byte_fifo
  import cabac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [WORD_W-1:0] push_bytes,
  input  logic [2:0]        push_cnt,
  input  logic              pop,
  output logic [PTR_W:0]    count,
  output logic [BYTE_W-1:0] head
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  // Storage write: byte i of the push lands at wr_ptr+i, wrapping modulo DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset && !clear && (3'(i) < push_cnt)) begin
        r_mem[r_wr_ptr + PTR_W'(i)] <= push_bytes[WORD_W-1-BYTE_W*i -: BYTE_W];
      end
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(push_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(pop);
      r_count  <= r_count + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop);
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/bitstream_byte_feeder.sv
// Slice byte feeder for the arithmetic bin decoder: word intake, byte FIFO, init value.
// Optional EPB_REMOVE_EN strips 00 00 03 emulation-prevention bytes on the write side.
module bitstream_byte_feeder
  import cabac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              request_byte,
  output logic [BYTE_W-1:0] data,
  output logic              byte_valid,
  output logic [15:0]       init_value,
  output logic              init_done,
  output logic              underflow
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  feeder_state_t     r_state;
  feeder_state_t     w_next_state;
  logic              r_eos;
  logic              r_underflow;
  logic [15:0]       r_init_value;
  logic [PTR_W:0]    w_count;
  logic [PTR_W:0]    w_free;
  logic [BYTE_W-1:0] w_head;
  logic              w_byte_valid;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_pop;
  logic [WORD_W-1:0] w_push_bytes;
  logic [2:0]        w_keep_cnt;
  logic [2:0]        w_push_cnt;

  assign w_free       = DEPTH_C - w_count;
  assign w_byte_valid = (w_count != '0);
  assign w_in_ready   = (r_state != IDLE) && !r_eos && (w_free >= (PTR_W+1)'(4));
  // The start cycle flushes the FIFO, so nothing is taken in on that edge.
  assign w_accept     = in_valid && w_in_ready && !start;
  assign w_push_cnt   = w_accept ? w_keep_cnt : 3'd0;

`ifdef EPB_REMOVE_EN
  logic [1:0]        r_zrun;
  logic [1:0]        w_zrun_next;
  logic [WORD_W-1:0] w_packed;
  logic [BYTE_W-1:0] w_cur;

  // Drop 03 after two zeros, compact survivors MSB-first, track the zero run.
  always_comb begin
    w_zrun_next  = r_zrun;
    w_packed     = '0;
    w_keep_cnt   = 3'd0;
    w_cur        = '0;
    w_push_bytes = '0;
    for (int i = 0; i < 4; i++) begin
      w_cur = in_word[WORD_W-1-BYTE_W*i -: BYTE_W];
      if ((w_zrun_next == 2'd2) && (w_cur == EPB_BYTE)) begin
        w_zrun_next = 2'd0;
      end else begin
        w_packed   = {w_packed[WORD_W-BYTE_W-1:0], w_cur};
        w_keep_cnt = w_keep_cnt + 3'd1;
        if (w_cur == 8'h00) begin
          w_zrun_next = (w_zrun_next == 2'd2) ? 2'd2 : (w_zrun_next + 2'd1);
        end else begin
          w_zrun_next = 2'd0;
        end
      end
    end
    case (w_keep_cnt)
      3'd2:    w_push_bytes = {w_packed[15:0], 16'h0000};
      3'd3:    w_push_bytes = {w_packed[23:0], 8'h00};
      default: w_push_bytes = w_packed;
    endcase
  end

  // Zero-run history carries across accepted words within a slice.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      r_zrun <= 2'd0;
    end else if (w_accept) begin
      r_zrun <= w_zrun_next;
    end else begin
      r_zrun <= r_zrun;
    end
  end
`else
  assign w_push_bytes = in_word;
  assign w_keep_cnt   = 3'd4;
`endif

  byte_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .push_bytes (w_push_bytes),
    .push_cnt   (w_push_cnt),
    .pop        (w_pop),
    .count      (w_count),
    .head       (w_head)
  );

  // Next state and pop decision.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_state = IDLE;
      end
      INIT_HI: begin
        if (w_byte_valid) begin
          w_pop        = 1'b1;
          w_next_state = INIT_LO;
        end else begin
          w_next_state = INIT_HI;
        end
      end
      INIT_LO: begin
        if (w_byte_valid) begin
          w_pop        = 1'b1;
          w_next_state = RUN;
        end else begin
          w_next_state = INIT_LO;
        end
      end
      RUN: begin
        w_pop        = request_byte && w_byte_valid;
        w_next_state = RUN;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (start) begin
      w_pop        = 1'b0;
      w_next_state = INIT_HI;
    end else begin
      w_pop        = w_pop;
    end
  end

  // State, end-of-slice, sticky underflow and init value capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_eos        <= 1'b0;
      r_underflow  <= 1'b0;
      r_init_value <= 16'h0000;
    end else if (start) begin
      r_state      <= INIT_HI;
      r_eos        <= 1'b0;
      r_underflow  <= 1'b0;
      r_init_value <= 16'h0000;
    end else begin
      r_state <= w_next_state;
      if (w_accept && in_last) begin
        r_eos <= 1'b1;
      end
      if ((r_state == INIT_HI) && w_pop) begin
        r_init_value[15:8] <= w_head;
      end
      if ((r_state == INIT_LO) && w_pop) begin
        r_init_value[7:0] <= w_head;
      end
      // Empty reads after the last word are legal trailing padding.
      if ((r_state == RUN) && request_byte && !w_byte_valid && !r_eos) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign data       = w_byte_valid ? w_head : 8'h00;
  assign byte_valid = w_byte_valid;
  assign init_value = r_init_value;
  assign init_done  = (r_state == RUN);
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_bitstream_byte_feeder.sv
// Directed self-checking bench for bitstream_byte_feeder (DEPTH=8).
module tb_bitstream_byte_feeder;
  import cabac_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] in_word;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        request_byte;
  logic [7:0]  data;
  logic        byte_valid;
  logic [15:0] init_value;
  logic        init_done;
  logic        underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bitstream_byte_feeder #(.DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_word      (in_word),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .request_byte (request_byte),
    .data         (data),
    .byte_valid   (byte_valid),
    .init_value   (init_value),
    .init_done    (init_done),
    .underflow    (underflow)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_drain [8];
  int         n_drain;

  initial begin
    reset = 1'b1; start = 1'b0; in_word = 32'h0; in_valid = 1'b0;
    in_last = 1'b0; request_byte = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_in_ready",   32'(in_ready),   32'h0);
    chk("rst_data",       32'(data),       32'h0);
    chk("rst_byte_valid", 32'(byte_valid), 32'h0);
    chk("rst_init_value", 32'(init_value), 32'h0);
    chk("rst_init_done",  32'(init_done),  32'h0);
    chk("rst_underflow",  32'(underflow),  32'h0);

    // Test 1: start, one word, init value captured.
    start = 1'b1; cyc(); start = 1'b0; #1;
    chk("t1_state_init_hi", 32'(dut.r_state), 32'(INIT_HI));
    in_word = 32'h8CD1_1234; in_valid = 1'b1; #1;
    chk("t1_in_ready", 32'(in_ready), 32'h1);
    cyc(); in_valid = 1'b0;
    cyc(); cyc(); #1;
    chk("t1_init_done",  32'(init_done),  32'h1);
    chk("t1_init_value", 32'(init_value), 32'h8CD1);
    chk("t1_data",       32'(data),       32'h12);
    chk("t1_byte_valid", 32'(byte_valid), 32'h1);

    // Test 3: fill to full, drain, simultaneous push/pop.
    in_word = 32'hA1A2_A3A4; in_valid = 1'b1; cyc(); in_valid = 1'b0; #1;
    chk("t3_count6",   32'(dut.w_count), 32'd6);
    chk("t3_ready_lo6", 32'(in_ready),   32'h0);
    request_byte = 1'b1; #1;
    chk("t3_pop_12", 32'(data), 32'h12); cyc();
    chk("t3_pop_34", 32'(data), 32'h34); cyc();
    request_byte = 1'b0; #1;
    chk("t3_ready_at4", 32'(in_ready), 32'h1);
    in_word = 32'hB1B2_B3B4; in_valid = 1'b1; cyc(); in_valid = 1'b0; #1;
    chk("t3_full_ready", 32'(in_ready),    32'h0);
    chk("t3_full_count", 32'(dut.w_count), 32'd8);
    chk("t3_full_head",  32'(data),        32'hA1);
    request_byte = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    request_byte = 1'b0; #1;
    chk("t3_ready_after_pop", 32'(in_ready),    32'h1);
    chk("t3_count4",          32'(dut.w_count), 32'd4);
    chk("t3_head_b1",         32'(data),        32'hB1);
    in_word = 32'hC1C2_C3C4; in_valid = 1'b1; request_byte = 1'b1;
    cyc(); in_valid = 1'b0; request_byte = 1'b0; #1;
    chk("t3_pushpop_count", 32'(dut.w_count), 32'd7);
    chk("t3_pushpop_head",  32'(data),        32'hB2);

    // Test 4: last word, drain past empty, no underflow.
    request_byte = 1'b1; cyc(); cyc(); cyc(); request_byte = 1'b0; #1;
    chk("t4_head_c1",  32'(data),     32'hC1);
    chk("t4_ready_pre", 32'(in_ready), 32'h1);
    in_word = 32'hD1D2_D3D4; in_valid = 1'b1; in_last = 1'b1;
    cyc(); in_valid = 1'b0; in_last = 1'b0; #1;
    chk("t4_count8",     32'(dut.w_count), 32'd8);
    chk("t4_ready_eos",  32'(in_ready),    32'h0);
    exp_drain = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    request_byte = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1; chk("t4_drain", 32'(data), 32'(exp_drain[i])); cyc();
    end
    #1;
    chk("t4_empty_data",  32'(data),       32'h0);
    chk("t4_empty_valid", 32'(byte_valid), 32'h0);
    cyc(); cyc(); request_byte = 1'b0; #1;
    chk("t4_no_underflow", 32'(underflow), 32'h0);
    chk("t4_ready_lo",     32'(in_ready),  32'h0);
    chk("t4_pad_data",     32'(data),      32'h0);

    // Test 2: underflow on an empty read with eos=0.
    start = 1'b1; cyc(); start = 1'b0; #1;
    chk("t2_init_done_cleared", 32'(init_done), 32'h0);
    chk("t2_ready_after_start", 32'(in_ready),  32'h1);
    in_word = 32'h8CD1_1234; in_valid = 1'b1; cyc(); in_valid = 1'b0;
    cyc(); cyc(); #1;
    chk("t2_init_value", 32'(init_value), 32'h8CD1);
    request_byte = 1'b1; #1;
    chk("t2_d0", 32'(data), 32'h12); cyc();
    chk("t2_d1", 32'(data), 32'h34); cyc();
    chk("t2_d2", 32'(data), 32'h00);
    chk("t2_uf_before", 32'(underflow), 32'h0);
    cyc(); request_byte = 1'b0; #1;
    chk("t2_underflow", 32'(underflow), 32'h1);

    // Test 5: start mid-RUN with 5 bytes buffered.
    in_word = 32'hAABB_CCDD; in_valid = 1'b1; cyc();
    in_word = 32'h1122_3344; cyc(); in_valid = 1'b0;
    request_byte = 1'b1; cyc(); cyc(); cyc(); request_byte = 1'b0; #1;
    chk("t5_count5", 32'(dut.w_count), 32'd5);
    chk("t5_head",   32'(data),        32'hDD);
    start = 1'b1; in_word = 32'h5566_7788; in_valid = 1'b1;
    cyc(); start = 1'b0; in_valid = 1'b0; #1;
    chk("t5_byte_valid", 32'(byte_valid),  32'h0);
    chk("t5_init_done",  32'(init_done),   32'h0);
    chk("t5_state",      32'(dut.r_state), 32'(INIT_HI));
    chk("t5_underflow",  32'(underflow),   32'h0);
    chk("t5_init_value", 32'(init_value),  32'h0);
    start = 1'b1; in_word = 32'h5566_7788; in_valid = 1'b1;
    cyc(); start = 1'b0; in_valid = 1'b0; #1;
    chk("t5_start_word_dropped", 32'(dut.w_count), 32'd0);

    // Test 6: emulation-prevention stripping (or not).
    in_word = 32'h0000_0312; in_valid = 1'b1; cyc();
    in_word = 32'h0000_0003; cyc(); in_valid = 1'b0;
    cyc(); #1;
    chk("t6_init_done",  32'(init_done),  32'h1);
    chk("t6_init_value", 32'(init_value), 32'h0000);
`ifdef EPB_REMOVE_EN
    exp_drain = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    n_drain = 4;
`else
    exp_drain = '{8'h03, 8'h12, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00};
    n_drain = 6;
`endif
    chk("t6_count", 32'(dut.w_count), 32'(n_drain));
    request_byte = 1'b1;
    for (int i = 0; i < n_drain; i++) begin
      #1; chk("t6_drain", 32'(data), 32'(exp_drain[i])); cyc();
    end
    request_byte = 1'b0; #1;
    chk("t6_empty", 32'(byte_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
